fp_multiplier_param: RTL and testbench

- Parametrised, multi-cycle IEEE-754-style floating-point multiplier.
- Next generation of our 32-bit FP multiplier. Adds generic exponent/mantissa widths, full special-case handling, round-to-nearest-even, an inexact flag and a ready/start/done handshake.
- Sits in the datapath as a single-issue coprocessor unit driven by a controller FSM.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_multiplier_param_if.sv | 33 +++
 rtl/fp_round_rne.sv | 34 +++
 rtl/fp_multiplier_param.sv | 222 ++++++++++++++++++++++
 tb/tb_fp_multiplier_param.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared types and constant helpers for the parametrised FP multiplier.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MULTIPLY,
    ST_NORMALIZE,
    ST_ROUND,
    ST_DONE
  } fp_mul_state_t;

  // Subnormals are flushed, so they classify as zero.
  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  // Exponent bias for an EXP_W-bit exponent field.
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << (exp_w + 1)) - 64'd1;
    return ones << (man_w - 1);
  endfunction

endpackage

// File: rtl/fp_multiplier_param_if.sv
// Start/ready/done handshake and result bus of the FP multiplier.
interface fp_multiplier_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ready_o;
  logic [W-1:0] product_o;
  logic         done_o;
  logic         nan_o;
  logic         infinit_o;
  logic         overflow_o;
  logic         underflow_o;
  logic         inexact_o;

  // Controller side.
  modport master (
    output start_i, a_i, b_i,
    input  ready_o, product_o, done_o, nan_o, infinit_o,
           overflow_o, underflow_o, inexact_o
  );

  // Multiplier side.
  modport slave (
    input  start_i, a_i, b_i,
    output ready_o, product_o, done_o, nan_o, infinit_o,
           overflow_o, underflow_o, inexact_o
  );
endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a normalised significand.
// The significand carries its hidden bit; a carry out of rounding
// renormalises to 1.0 and bumps the exponent.
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]             sig,
  input  logic                       guard,
  input  logic                       sticky,
  input  logic signed [EXP_W+1:0]    exp_pre,
  output logic [MAN_W-1:0]           frac,
  output logic signed [EXP_W+1:0]    exp_post,
  output logic                       inexact
);
  localparam int XW = EXP_W + 2;

  logic             inc;
  logic [MAN_W+1:0] sum;

  // Increment on G and (S or LSB); handle the carry-out renormalisation.
  always_comb begin
    inc      = guard & (sticky | sig[0]);
    sum      = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
    frac     = sum[MAN_W-1:0];
    exp_post = exp_pre;
    if (sum[MAN_W+1]) begin
      frac     = '0;
      exp_post = exp_pre + XW'(1);
    end
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/fp_multiplier_param.sv
// Multi-cycle IEEE-754-style multiplier: UNPACK, MULTIPLY, NORMALIZE,
// ROUND, DONE, one cycle each. Specials are resolved in UNPACK and carried
// down the pipe so every operation has the same latency.
module fp_multiplier_param
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                 clk,
  input logic                 rst,
  fp_multiplier_param_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int PRD_W = 2 * MAN_W + 2;
  localparam int XW    = EXP_W + 2;

  localparam logic signed [XW-1:0] BIAS_X  = XW'(bias(EXP_W));
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [63:0]          QNAN_L   = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN     = QNAN_L[W-1:0];

  fp_mul_state_t state_q, state_d;
  logic          accept;

  // Operand capture
  logic [W-1:0] a_q, b_q;

  // UNPACK stage
  fp_class_t          cls_a, cls_b;
  logic               any_nan, any_inf, any_zero;
  logic [SIG_W-1:0]   sig_a_q, sig_b_q;
  logic [EXP_W-1:0]   ea_q, eb_q;
  logic               sp_nan_q, sp_inf_q, sp_zero_q, inf_any_q;

  // MULTIPLY stage
  logic               sign_q;
  logic signed [XW-1:0] exp_m_q;
  logic [PRD_W-1:0]   prod_q;

  // NORMALIZE stage
  logic [SIG_W-1:0]   sig_n_q;
  logic               g_q, s_q;
  logic signed [XW-1:0] exp_n_q;

  // ROUND stage
  logic [MAN_W-1:0]   frac_r;
  logic signed [XW-1:0] exp_r;
  logic               inx_r;
  logic [W-1:0]       res_p;
  logic               res_nan, res_ovf, res_unf, res_inx;

  // Result registers
  logic [W-1:0] product_q;
  logic         done_q, nan_q, inf_q, ovf_q, unf_q, inx_q;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (e == EXP_ONES) return (f == '0) ? CLS_INF : CLS_NAN;
    if (e == '0)       return CLS_ZERO;
    return CLS_NORMAL;
  endfunction

  assign accept = (state_q == ST_IDLE) && bus.start_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed walk through the stages once started
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (bus.start_i) state_d = ST_UNPACK;
      ST_UNPACK:    state_d = ST_MULTIPLY;
      ST_MULTIPLY:  state_d = ST_NORMALIZE;
      ST_NORMALIZE: state_d = ST_ROUND;
      ST_ROUND:     state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Operands are captured only on accept and held while busy
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a_i;
      b_q <= bus.b_i;
    end
  end

  // Operand classification; inf*0 is folded into the NaN case
  always_comb begin
    cls_a    = classify(a_q[W-2:MAN_W], a_q[MAN_W-1:0]);
    cls_b    = classify(b_q[W-2:MAN_W], b_q[MAN_W-1:0]);
    any_nan  = (cls_a == CLS_NAN)  || (cls_b == CLS_NAN);
    any_inf  = (cls_a == CLS_INF)  || (cls_b == CLS_INF);
    any_zero = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);
  end

  // UNPACK: split fields, attach hidden bit, latch special-case decision
  always_ff @(posedge clk) begin
    if (state_q == ST_UNPACK) begin
      sig_a_q   <= {cls_a == CLS_NORMAL, a_q[MAN_W-1:0]};
      sig_b_q   <= {cls_b == CLS_NORMAL, b_q[MAN_W-1:0]};
      ea_q      <= a_q[W-2:MAN_W];
      eb_q      <= b_q[W-2:MAN_W];
      sp_nan_q  <= any_nan | (any_inf & any_zero);
      sp_inf_q  <= any_inf;
      sp_zero_q <= any_zero;
      inf_any_q <= any_inf;
    end
  end

  // MULTIPLY: sign, biased exponent sum, full significand product
  always_ff @(posedge clk) begin
    if (state_q == ST_MULTIPLY) begin
      sign_q  <= a_q[W-1] ^ b_q[W-1];
      exp_m_q <= $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS_X;
      prod_q  <= PRD_W'(sig_a_q) * PRD_W'(sig_b_q);
    end
  end

  // NORMALIZE: product is in [1,4); fold the top bit into the exponent
  always_ff @(posedge clk) begin
    if (state_q == ST_NORMALIZE) begin
      if (prod_q[PRD_W-1]) begin
        sig_n_q <= prod_q[PRD_W-1 -: SIG_W];
        g_q     <= prod_q[MAN_W];
        s_q     <= |prod_q[MAN_W-1:0];
        exp_n_q <= exp_m_q + XW'(1);
      end else begin
        sig_n_q <= prod_q[PRD_W-2 -: SIG_W];
        g_q     <= prod_q[MAN_W-1];
        s_q     <= |prod_q[MAN_W-2:0];
        exp_n_q <= exp_m_q;
      end
    end
  end

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sig      (sig_n_q),
    .guard    (g_q),
    .sticky   (s_q),
    .exp_pre  (exp_n_q),
    .frac     (frac_r),
    .exp_post (exp_r),
    .inexact  (inx_r)
  );

  // Result selection in priority order: NaN, inf, zero, overflow, underflow, normal
  always_comb begin
    res_p   = {sign_q, exp_r[EXP_W-1:0], frac_r};
    res_nan = 1'b0;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_inx = inx_r;
    if (sp_nan_q) begin
      res_p   = QNAN;
      res_nan = 1'b1;
      res_inx = 1'b0;
    end else if (sp_inf_q) begin
      res_p   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      res_inx = 1'b0;
    end else if (sp_zero_q) begin
      res_p   = {sign_q, {(W-1){1'b0}}};
      res_inx = 1'b0;
    end else if (!exp_r[XW-1] && (exp_r >= EXP_MAX)) begin
      res_p   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
      res_inx = 1'b1;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      res_p   = {sign_q, {(W-1){1'b0}}};
      res_unf = 1'b1;
      res_inx = 1'b1;
    end
  end

  // Result/flag registers: cleared on accept, loaded leaving ROUND, done for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_q <= '0;
      done_q    <= 1'b0;
      nan_q     <= 1'b0;
      inf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inx_q     <= 1'b0;
    end else if (accept) begin
      done_q <= 1'b0;
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      inx_q  <= 1'b0;
    end else if (state_q == ST_ROUND) begin
      product_q <= res_p;
      done_q    <= 1'b1;
      nan_q     <= res_nan;
      inf_q     <= inf_any_q;
      ovf_q     <= res_ovf;
      unf_q     <= res_unf;
      inx_q     <= res_inx;
    end else if (state_q == ST_DONE) begin
      done_q <= 1'b0;
    end
  end

  assign bus.ready_o     = (state_q == ST_IDLE);
  assign bus.product_o   = product_q;
  assign bus.done_o      = done_q;
  assign bus.nan_o       = nan_q;
  assign bus.infinit_o   = inf_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
  assign bus.inexact_o   = inx_q;

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Directed bench for fp_multiplier_param: single precision and half precision
// instances, expected results queued at issue and popped on done_o.
module tb_fp_multiplier_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_multiplier_param_if #(.EXP_W(8), .MAN_W(23)) sif ();
  fp_multiplier_param_if #(.EXP_W(5), .MAN_W(10)) hif ();

  fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  // flags packed as {nan, infinit, overflow, underflow, inexact}
  typedef struct {
    logic [31:0] prod;
    logic [4:0]  flg;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] prod_of(input bit h);
    return h ? {16'h0, hif.product_o} : sif.product_o;
  endfunction

  function automatic logic [4:0] flg_of(input bit h);
    return h ? {hif.nan_o, hif.infinit_o, hif.overflow_o, hif.underflow_o, hif.inexact_o}
             : {sif.nan_o, sif.infinit_o, sif.overflow_o, sif.underflow_o, sif.inexact_o};
  endfunction

  function automatic logic done_of(input bit h);
    return h ? hif.done_o : sif.done_o;
  endfunction

  function automatic logic ready_of(input bit h);
    return h ? hif.ready_o : sif.ready_o;
  endfunction

  task automatic drive(input bit h, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (h) begin
      hif.start_i = s; hif.a_i = a[15:0]; hif.b_i = b[15:0];
    end else begin
      sif.start_i = s; sif.a_i = a; sif.b_i = b;
    end
  endtask

  // One operation; poke>0 re-asserts start_i with other operands in that busy cycle.
  task automatic run_op(input string tag, input bit h, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ep, input logic [4:0] ef, input int poke);
    int   n;
    exp_t e;
    @(negedge clk);
    check({tag, ":ready"}, 32'(ready_of(h)), 32'd1);
    drive(h, 1'b1, a, b);
    sb.push_back('{prod: ep, flg: ef});
    @(posedge clk);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (n == poke) begin
        drive(h, 1'b1, 32'h4100_4100, 32'h4100_4100);
        check({tag, ":busy_ready"}, 32'(ready_of(h)), 32'd0);
      end else begin
        drive(h, 1'b0, a, b);
      end
      if (done_of(h) || n >= 20) break;
    end
    // done_o is expected in the fifth cycle counted after the accept cycle
    check({tag, ":latency"}, 32'(n), 32'd5);
    e = sb.pop_front();
    check({tag, ":product"}, prod_of(h), e.prod);
    check({tag, ":flags"}, 32'(flg_of(h)), 32'(e.flg));
    @(negedge clk);
    check({tag, ":done_pulse"}, 32'(done_of(h)), 32'd0);
    check({tag, ":hold"}, prod_of(h), e.prod);
    check({tag, ":ready_after"}, 32'(ready_of(h)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dn;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst:product", prod_of(1'b0), 32'h0);
    check("rst:flags", 32'(flg_of(1'b0)), 32'h0);
    check("rst:done", 32'(done_of(1'b0)), 32'h0);
    check("rst:ready", 32'(ready_of(1'b0)), 32'h1);
    rst = 1'b0;

    run_op("basic",     1'b0, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 0);
    run_op("neg",       1'b0, 32'hBF80_0000, 32'h4000_0000, 32'hC000_0000, 5'b00000, 0);
    run_op("rnd_down",  1'b0, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 5'b00001, 0);
    run_op("rnd_tie",   1'b0, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 5'b00001, 0);
    run_op("inf_zero",  1'b0, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b11000, 0);
    run_op("nan_in",    1'b0, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000, 0);
    run_op("neg_inf",   1'b0, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 5'b01000, 0);
    run_op("overflow",  1'b0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 5'b00101, 0);
    run_op("underflow", 1'b0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 5'b00011, 0);
    run_op("ftz",       1'b0, 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 5'b00000, 0);
    run_op("poke",      1'b0, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 2);

    // Reset in NORMALIZE: outputs clear at once and the operation never completes
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h3F80_0001, 32'h3FC0_0000);
    @(posedge clk);
    @(negedge clk); drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst:product", prod_of(1'b0), 32'h0);
    check("midrst:flags", 32'(flg_of(1'b0)), 32'h0);
    check("midrst:done", 32'(done_of(1'b0)), 32'h0);
    check("midrst:ready", 32'(ready_of(1'b0)), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_of(1'b0)) dn++;
    end
    check("midrst:no_done", 32'(dn), 32'd0);

    run_op("h_basic", 1'b1, 32'h3C00, 32'h4000, 32'h4000, 5'b00000, 0);
    run_op("h_ovf",   1'b1, 32'h7BFF, 32'h4000, 32'h7C00, 5'b00101, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
